// File: rtl/value_sampler_pkg.sv
// value_sampler_pkg: shared types and constants for the value_sampler block.
// Holds the serialiser state encoding, the beat-count helper and the
// drop-counter width used by the top level.
package value_sampler_pkg;

  localparam int DROP_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  // Number of CHUNK-wide beats needed to carry a DATA-wide value.
  function automatic int num_chunks(input int data_width, input int chunk_width);
    return (data_width + chunk_width - 1) / chunk_width;
  endfunction

endpackage

// File: rtl/value_sampler_fifo.sv
// value_sampler_fifo: small synchronous FIFO with a combinational head read.
// The head is visible as soon as an entry is written so the serialiser can
// load it in the same cycle it pops. Push while full is only legal when a pop
// happens in the same cycle; the caller guarantees that.
module value_sampler_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    count_reg;

  // Storage array: no reset so it can map onto distributed RAM.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + LW'(1);
        2'b01:   count_reg <= count_reg - LW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign full  = (count_reg == LW'(DEPTH));
  assign empty = (count_reg == '0);
  assign level = count_reg;

endmodule

// File: rtl/value_sampler.sv
// value_sampler: captures a wide value whenever it changes while sampling is
// enabled, buffers captures in a FIFO and streams each one out LSB-first as
// CHUNK_WIDTH-bit beats on a valid/ready interface.
// Optional build macro VALUE_SAMPLER_TIMESTAMP_EN: stores a free-running cycle
// count with every capture and emits it as an extra leading beat.
module value_sampler
  import value_sampler_pkg::*;
#(
  parameter int DATA_WIDTH  = 129,
  parameter int CHUNK_WIDTH = 32,
  parameter int DEPTH       = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  i_value,
  input  logic                   i_sample_en,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [CHUNK_WIDTH-1:0] o_data,
  output logic [2:0]             o_idx,
  output logic                   o_last,
  output logic [$clog2(DEPTH):0] o_level,
  output logic [DROP_CNT_W-1:0]  o_drop_cnt
);

  localparam int NUM_CHUNKS = num_chunks(DATA_WIDTH, CHUNK_WIDTH);
`ifdef VALUE_SAMPLER_TIMESTAMP_EN
  localparam int NUM_BEATS  = NUM_CHUNKS + 1;
  localparam int ENTRY_W    = DATA_WIDTH + CHUNK_WIDTH;
`else
  localparam int NUM_BEATS  = NUM_CHUNKS;
  localparam int ENTRY_W    = DATA_WIDTH;
`endif
  localparam int         SREG_W   = NUM_BEATS * CHUNK_WIDTH;
  localparam logic [2:0] LAST_IDX = 3'(NUM_BEATS - 1);

  logic [DATA_WIDTH-1:0] prev_reg;
  logic                  have_prev_reg;
  logic                  capture;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ENTRY_W-1:0]    push_entry;
  logic [ENTRY_W-1:0]    fifo_head;
  logic [DROP_CNT_W-1:0] drop_cnt_reg;
  state_t                state_reg;
  state_t                state_next;
  logic [SREG_W-1:0]     sreg_reg;
  logic [2:0]            idx_reg;
  logic                  valid_reg;
  logic                  handshake;
  logic                  load_beat;
  logic                  shift_beat;
  logic                  finish;

  // A capture is the first enabled sample after reset, or any enabled change.
  assign capture = i_sample_en && (!have_prev_reg || (i_value != prev_reg));

  // Track the last captured value, even when the capture itself is dropped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_reg      <= '0;
      have_prev_reg <= 1'b0;
    end else if (capture) begin
      prev_reg      <= i_value;
      have_prev_reg <= 1'b1;
    end
  end

`ifdef VALUE_SAMPLER_TIMESTAMP_EN
  logic [CHUNK_WIDTH-1:0] ts_reg;

  // Free-running cycle counter; its value at the capture edge tags the entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ts_reg <= '0;
    end else begin
      ts_reg <= ts_reg + CHUNK_WIDTH'(1);
    end
  end

  // Timestamp in the low chunk so it leaves first.
  assign push_entry = {i_value, ts_reg};
`else
  assign push_entry = i_value;
`endif

  // A full FIFO still accepts a push when the serialiser pops the same cycle.
  assign fifo_push = capture && (!fifo_full || fifo_pop);

  value_sampler_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (o_level)
  );

  // Saturating count of captures lost because the FIFO had no room.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      drop_cnt_reg <= '0;
    end else if (capture && fifo_full && !fifo_pop && (drop_cnt_reg != '1)) begin
      drop_cnt_reg <= drop_cnt_reg + DROP_CNT_W'(1);
    end
  end

  // Serialiser state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  assign handshake = valid_reg && i_ready;

  // Next-state and beat control; the final beat reloads directly when more data waits.
  always_comb begin
    state_next = state_reg;
    fifo_pop   = 1'b0;
    load_beat  = 1'b0;
    shift_beat = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        fifo_pop   = 1'b1;
        load_beat  = 1'b1;
        state_next = SEND;
      end
      SEND: begin
        if (handshake) begin
          if (o_last) begin
            if (!fifo_empty) begin
              fifo_pop  = 1'b1;
              load_beat = 1'b1;
            end else begin
              finish     = 1'b1;
              state_next = IDLE;
            end
          end else begin
            shift_beat = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Shift register, beat index and valid; everything holds while stalled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sreg_reg  <= '0;
      idx_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (load_beat) begin
      sreg_reg  <= SREG_W'(fifo_head);
      idx_reg   <= '0;
      valid_reg <= 1'b1;
    end else if (shift_beat) begin
      sreg_reg  <= sreg_reg >> CHUNK_WIDTH;
      idx_reg   <= idx_reg + 3'd1;
    end else if (finish) begin
      sreg_reg  <= '0;
      idx_reg   <= '0;
      valid_reg <= 1'b0;
    end
  end

  assign o_valid    = valid_reg;
  assign o_data     = sreg_reg[CHUNK_WIDTH-1:0];
  assign o_idx      = idx_reg;
  assign o_last     = valid_reg && (idx_reg == LAST_IDX);
  assign o_drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_value_sampler.sv
// tb_value_sampler: directed self-checking bench for value_sampler.
// The default build exercises the plain data path; with
// VALUE_SAMPLER_TIMESTAMP_EN defined it runs the reset and timestamp scenarios.
module tb_value_sampler;

  localparam int DW = 129;
  localparam int CW = 32;

  localparam logic [128:0] V1 = 129'h1_0000_0002_0000_0003_0000_0004_0000_0005;
  localparam logic [128:0] V2 = 129'h0_0BAD_F00D_1234_5678_9ABC_DEF0_0000_0042;
  localparam logic [128:0] V3 = 129'h1_5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA;
  localparam logic [128:0] V5 = 129'h1_1111_2222_3333_4444_5555_6666_7777_8888;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] i_value = '0;
  logic          i_sample_en = 1'b0;
  logic          i_ready = 1'b0;
  logic          o_valid;
  logic [CW-1:0] o_data;
  logic [2:0]    o_idx;
  logic          o_last;
  logic [2:0]    o_level;
  logic [7:0]    o_drop_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clock = ~clock;

  value_sampler #(
    .DATA_WIDTH  (DW),
    .CHUNK_WIDTH (CW),
    .DEPTH       (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .i_value     (i_value),
    .i_sample_en (i_sample_en),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .o_idx       (o_idx),
    .o_last      (o_last),
    .o_level     (o_level),
    .o_drop_cnt  (o_drop_cnt)
  );

  // Advance one clock and land just after the edge (sample/drive point).
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Wait (bounded) until o_valid is seen at a sample point.
  task automatic wait_valid(input int budget, output bit ok);
    ok = o_valid;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      ok = o_valid;
    end
  endtask

  function automatic logic [31:0] chunk_of(input logic [128:0] v, input int k);
    logic [159:0] w;
    w = 160'(v);
    return w[32*k +: 32];
  endfunction

  function automatic logic [128:0] wval(input int k);
    logic [128:0] w;
    w = '0;
    for (int j = 0; j < 4; j++) begin
      w[32*j +: 32] = 32'hA000_0000 | 32'(k << 8) | 32'(j);
    end
    w[128] = k[0];
    return w;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    vec_cnt++;
    if ({o_valid, o_data, o_idx, o_last, o_level, o_drop_cnt} !== '0)
      begin
        err_cnt++;
        $display("FAIL reset_state: got valid=%0b data=%h idx=%0d last=%0b level=%0d drop=%0d expected all 0",
                 o_valid, o_data, o_idx, o_last, o_level, o_drop_cnt);
      end
  endtask

  task automatic test_single_capture();
    logic [31:0] exp_d [5];
    exp_d = '{32'h5, 32'h4, 32'h3, 32'h2, 32'h1};
    i_sample_en = 1'b1;
    i_value     = V1;
    i_ready     = 1'b1;
    reset       = 1'b1;
    tick();  // capture edge N
    vec_cnt++;
    if (o_level !== 3'd1 || o_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL lat_edge_n: got level=%0d valid=%0b expected level=1 valid=0", o_level, o_valid);
    end
    tick();  // edge N+1: LOAD
    vec_cnt++;
    if (o_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL lat_edge_n1: got valid=%0b expected 0", o_valid);
    end
    tick();  // edge N+2: SEND
    for (int k = 0; k < 5; k++) begin
      vec_cnt++;
      if (o_valid !== 1'b1 || o_data !== exp_d[k] || o_idx !== 3'(k) || o_last !== (k == 4)) begin
        err_cnt++;
        $display("FAIL single_beat%0d: got valid=%0b data=%h idx=%0d last=%0b expected valid=1 data=%h idx=%0d last=%0b",
                 k, o_valid, o_data, o_idx, o_last, exp_d[k], k, (k == 4));
      end
      tick();
    end
    vec_cnt++;
    if (o_valid !== 1'b0 || o_level !== 3'd0) begin
      err_cnt++;
      $display("FAIL single_end: got valid=%0b level=%0d expected valid=0 level=0", o_valid, o_level);
    end
  endtask

  task automatic test_hold_and_disable();
    int beats;
    int max_level;
    bit quiet;
    beats     = 0;
    max_level = 0;
    i_value   = V2;
    for (int c = 0; c < 25; c++) begin
      if (o_valid && i_ready) beats++;
      if (int'(o_level) > max_level) max_level = int'(o_level);
      tick();
    end
    vec_cnt++;
    if (beats != 5 || max_level != 1) begin
      err_cnt++;
      $display("FAIL hold_one_capture: got beats=%0d max_level=%0d expected beats=5 max_level=1", beats, max_level);
    end
    i_sample_en = 1'b0;
    quiet = 1'b1;
    for (int c = 0; c < 10; c++) begin
      i_value = V3 ^ 129'(c);
      tick();
      if (o_valid !== 1'b0 || o_level !== 3'd0) quiet = 1'b0;
    end
    vec_cnt++;
    if (!quiet) begin
      err_cnt++;
      $display("FAIL disabled_no_capture: got activity (valid=%0b level=%0d) expected none", o_valid, o_level);
    end
  endtask

  task automatic test_overflow();
    int cap;
    int k;
    i_ready     = 1'b0;
    i_sample_en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      i_value = wval(c);
      tick();
    end
    vec_cnt++;
    if (o_level !== 3'd4 || o_drop_cnt !== 8'd5) begin
      err_cnt++;
      $display("FAIL overflow_counts: got level=%0d drop=%0d expected level=4 drop=5", o_level, o_drop_cnt);
    end
    vec_cnt++;
    if (o_valid !== 1'b1 || o_data !== chunk_of(wval(0), 0) || o_idx !== 3'd0) begin
      err_cnt++;
      $display("FAIL overflow_stalled_head: got valid=%0b data=%h idx=%0d expected valid=1 data=%h idx=0",
               o_valid, o_data, o_idx, chunk_of(wval(0), 0));
    end
    i_sample_en = 1'b0;
    i_ready     = 1'b1;
    for (int b = 0; b < 25; b++) begin
      cap = b / 5;
      k   = b % 5;
      vec_cnt++;
      if (o_valid !== 1'b1 || o_data !== chunk_of(wval(cap), k) || o_idx !== 3'(k) || o_last !== (k == 4)) begin
        err_cnt++;
        $display("FAIL drain_beat%0d: got valid=%0b data=%h idx=%0d last=%0b expected valid=1 data=%h idx=%0d last=%0b",
                 b, o_valid, o_data, o_idx, o_last, chunk_of(wval(cap), k), k, (k == 4));
      end
      tick();
    end
    vec_cnt++;
    if (o_valid !== 1'b0 || o_level !== 3'd0 || o_drop_cnt !== 8'd5) begin
      err_cnt++;
      $display("FAIL drain_end: got valid=%0b level=%0d drop=%0d expected valid=0 level=0 drop=5",
               o_valid, o_level, o_drop_cnt);
    end
  endtask

  task automatic test_backpressure();
    int bidx;
    int cap;
    int k;
    bit stall;
    logic [31:0] sd;
    logic [2:0] si;
    logic sl;
    bidx  = 0;
    stall = 1'b0;
    sd    = '0;
    si    = '0;
    sl    = 1'b0;
    i_sample_en = 1'b1;
    for (int c = 0; c < 300 && bidx < 15; c++) begin
      if (c < 3) i_value = wval(20 + c);
      if (stall) begin
        vec_cnt++;
        if (o_data !== sd || o_idx !== si || o_last !== sl) begin
          err_cnt++;
          $display("FAIL stall_hold: got data=%h idx=%0d last=%0b expected data=%h idx=%0d last=%0b",
                   o_data, o_idx, o_last, sd, si, sl);
        end
      end
      i_ready = 1'($urandom_range(0, 1));
      if (o_valid && i_ready) begin
        cap = bidx / 5;
        k   = bidx % 5;
        vec_cnt++;
        if (o_data !== chunk_of(wval(20 + cap), k) || o_idx !== 3'(k) || o_last !== (k == 4)) begin
          err_cnt++;
          $display("FAIL bp_beat%0d: got data=%h idx=%0d last=%0b expected data=%h idx=%0d last=%0b",
                   bidx, o_data, o_idx, o_last, chunk_of(wval(20 + cap), k), k, (k == 4));
        end
        bidx++;
      end
      stall = o_valid && !i_ready;
      sd    = o_data;
      si    = o_idx;
      sl    = o_last;
      tick();
    end
    vec_cnt++;
    if (bidx != 15 || o_drop_cnt !== 8'd5) begin
      err_cnt++;
      $display("FAIL bp_total: got beats=%0d drop=%0d expected beats=15 drop=5", bidx, o_drop_cnt);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    bit found;
    i_ready     = 1'b1;
    i_sample_en = 1'b1;
    i_value     = V5;
    found = (o_valid === 1'b1 && o_idx === 3'd2);
    for (int c = 0; c < 40 && !found; c++) begin
      tick();
      found = (o_valid === 1'b1 && o_idx === 3'd2);
    end
    vec_cnt++;
    if (!found) begin
      err_cnt++;
      $display("FAIL reach_idx2: got idx=%0d valid=%0b expected idx=2 valid=1", o_idx, o_valid);
    end
    #2;
    reset = 1'b0;
    #1;
    vec_cnt++;
    if ({o_valid, o_data, o_idx, o_last, o_level, o_drop_cnt} !== '0) begin
      err_cnt++;
      $display("FAIL async_reset: got valid=%0b data=%h idx=%0d last=%0b level=%0d drop=%0d expected all 0",
               o_valid, o_data, o_idx, o_last, o_level, o_drop_cnt);
    end
    tick();
    reset = 1'b1;
    tick();
    vec_cnt++;
    if (o_level !== 3'd1) begin
      err_cnt++;
      $display("FAIL recapture_level: got level=%0d expected 1", o_level);
    end
    wait_valid(10, ok);
    vec_cnt++;
    if (!ok) begin
      err_cnt++;
      $display("FAIL recapture_timeout: got valid=0 expected valid=1 within 10 cycles");
    end
    for (int k = 0; k < 5; k++) begin
      vec_cnt++;
      if (o_valid !== 1'b1 || o_data !== chunk_of(V5, k) || o_idx !== 3'(k) || o_last !== (k == 4)) begin
        err_cnt++;
        $display("FAIL recapture_beat%0d: got valid=%0b data=%h idx=%0d last=%0b expected valid=1 data=%h idx=%0d last=%0b",
                 k, o_valid, o_data, o_idx, o_last, chunk_of(V5, k), k, (k == 4));
      end
      tick();
    end
  endtask

  task automatic test_timestamp();
    bit ok;
    logic [31:0] exp_d [6];
    exp_d = '{32'h7, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1};
    i_sample_en = 1'b0;
    i_value     = V1;
    i_ready     = 1'b1;
    reset       = 1'b1;
    for (int c = 0; c < 7; c++) tick();
    i_sample_en = 1'b1;
    tick();  // capture edge with counter at 7
    wait_valid(10, ok);
    vec_cnt++;
    if (!ok) begin
      err_cnt++;
      $display("FAIL ts_timeout: got valid=0 expected valid=1 within 10 cycles");
    end
    for (int k = 0; k < 6; k++) begin
      vec_cnt++;
      if (o_valid !== 1'b1 || o_data !== exp_d[k] || o_idx !== 3'(k) || o_last !== (k == 5)) begin
        err_cnt++;
        $display("FAIL ts_beat%0d: got valid=%0b data=%h idx=%0d last=%0b expected valid=1 data=%h idx=%0d last=%0b",
                 k, o_valid, o_data, o_idx, o_last, exp_d[k], k, (k == 5));
      end
      tick();
    end
    vec_cnt++;
    if (o_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL ts_end: got valid=%0b expected 0", o_valid);
    end
  endtask

  initial begin
    #1;
    test_reset();
`ifdef VALUE_SAMPLER_TIMESTAMP_EN
    test_timestamp();
`else
    test_single_capture();
    test_hold_and_disable();
    test_overflow();
    test_backpressure();
    test_async_reset();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule
